// File: rtl/mac_vector_engine.sv
// Multi-lane signed multiply-accumulate engine: 3-stage product/reduce/accumulate
// pipeline with a saturating per-vector accumulator and a valid/ready result port.
module mac_vector_engine #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      soft_clr_i,
  input  logic                      relu_en_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_last_i,
  input  logic [LANES*DATA_W-1:0]   in_data_i,
  input  logic [LANES*DATA_W-1:0]   in_weight_i,
  input  logic [ACC_W-1:0]          in_bias_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ACC_W-1:0]          out_data_o,
  output logic                      out_ovf_o,
  output logic [CNT_W-1:0]          out_beats_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic ce_c, in_ready_c, accept_c;

  logic                     s1_valid_q, s1_last_q, s1_relu_q;
  logic signed [ACC_W-1:0]  s1_bias_q;
  logic signed [PROD_W-1:0] s1_prod_q [LANES];
  logic signed [PROD_W-1:0] prod_d    [LANES];

  logic                     s2_valid_q, s2_last_q, s2_relu_q;
  logic signed [ACC_W-1:0]  s2_bias_q;
  logic signed [SUM_W-1:0]  s2_sum_q, sum_d;

  logic                     s3_valid_q, s3_last_q, s3_relu_q;
  logic signed [ACC_W-1:0]  acc_q, acc_base_c, acc_d;
  logic signed [ACC_W:0]    wide_c;
  logic                     sat_c;
  logic                     first_q, vovf_q;
  logic [CNT_W-1:0]         cnt_q;

  logic                     out_valid_q, out_ovf_q;
  logic [ACC_W-1:0]         out_data_q;
  logic [CNT_W-1:0]         out_beats_q;

  // Global clock enable: everything freezes while a result waits for the consumer.
  assign ce_c       = !(out_valid_q && !out_ready_i);
  assign in_ready_c = ce_c;
  assign accept_c   = in_valid_i && in_ready_c;
  assign in_ready_o = in_ready_c;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      logic signed [DATA_W-1:0] a, b;
      a = in_data_i[i*DATA_W +: DATA_W];
      b = in_weight_i[i*DATA_W +: DATA_W];
      prod_d[i] = PROD_W'(a) * PROD_W'(b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_bias_q  <= '0;
      for (int unsigned i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
    end else if (soft_clr_i) begin
      s1_valid_q <= 1'b0;
    end else if (ce_c) begin
      s1_valid_q <= accept_c;
      s1_last_q  <= in_last_i;
      s1_relu_q  <= relu_en_i;
      s1_bias_q  <= in_bias_i;
      for (int unsigned i = 0; i < LANES; i++) s1_prod_q[i] <= prod_d[i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < LANES; i++) sum_d = sum_d + SUM_W'(s1_prod_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_relu_q  <= 1'b0;
      s2_bias_q  <= '0;
      s2_sum_q   <= '0;
    end else if (soft_clr_i) begin
      s2_valid_q <= 1'b0;
    end else if (ce_c) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_relu_q  <= s1_relu_q;
      s2_bias_q  <= s1_bias_q;
      s2_sum_q   <= sum_d;
    end
  end

  // One guard bit above the accumulator detects overflow; clamp to the signed range.
  always_comb begin
    acc_base_c = first_q ? s2_bias_q : acc_q;
    wide_c     = (ACC_W+1)'(acc_base_c) + (ACC_W+1)'(s2_sum_q);
    sat_c      = wide_c[ACC_W] != wide_c[ACC_W-1];
    acc_d      = sat_c ? (wide_c[ACC_W] ? ACC_MIN : ACC_MAX) : wide_c[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_relu_q  <= 1'b0;
      acc_q      <= '0;
      first_q    <= 1'b1;
      vovf_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (soft_clr_i) begin
      s3_valid_q <= 1'b0;
      first_q    <= 1'b1;
      vovf_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (ce_c) begin
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      s3_relu_q  <= s2_relu_q;
      if (s2_valid_q) begin
        acc_q   <= acc_d;
        vovf_q  <= (!first_q && vovf_q) || sat_c;
        cnt_q   <= first_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
        first_q <= s2_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (soft_clr_i) begin
      out_valid_q <= 1'b0;
    end else if (ce_c) begin
      if (s3_valid_q && s3_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= (s3_relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
        out_ovf_q   <= vovf_q;
        out_beats_q <= cnt_q;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_beats_o = out_beats_q;

endmodule
